// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: bus words, RAM handshake states and
// the arbiter FSM encoding (exposed so benches can probe the state register).
package mem_request_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DACC = 2'b01,
        IACC = 2'b10,
        RESP = 2'b11
    } arb_state_t;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Request-unit and RAM-port signals of the arbiter. The slave view belongs to the
// arbiter; the master view drives requests and models the RAM.
interface mem_request_arbiter_if;
    import mem_request_arbiter_pkg::*;

    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    word_t     imemload;
    logic      dhit;
    word_t     dmemload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ramstate,
        output ihit, imemload, dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ramstate,
        input  ihit, imemload, dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, memerr
    );

endinterface

// File: rtl/mem_request_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port (data wins), returning
// one-cycle hit or error pulses with registered load data.
module mem_request_arbiter
    import mem_request_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic                  CLK,
    input logic                  nRST,
    mem_request_arbiter_if.slave bus
);

    arb_state_t       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ram_ren_q,   ram_ren_d;
    logic             ram_wen_q,   ram_wen_d;
    word_t            ram_addr_q,  ram_addr_d;
    word_t            ram_store_q, ram_store_d;
    logic             ihit_q,      ihit_d;
    logic             dhit_q,      dhit_d;
    logic             memerr_q,    memerr_d;
    word_t            imemload_q,  imemload_d;
    word_t            dmemload_q,  dmemload_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        imemload_d  = imemload_q;
        dmemload_d  = dmemload_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        memerr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.dmemREN || bus.dmemWEN) begin
                    // A simultaneous read and write request is resolved as a write.
                    state_d     = DACC;
                    cnt_d       = '0;
                    ram_addr_d  = bus.dmemaddr;
                    ram_store_d = bus.dmemstore;
                    ram_wen_d   = bus.dmemWEN;
                    ram_ren_d   = !bus.dmemWEN;
                end else if (bus.imemREN) begin
                    state_d    = IACC;
                    cnt_d      = '0;
                    ram_addr_d = bus.imemaddr;
                    ram_wen_d  = 1'b0;
                    ram_ren_d  = 1'b1;
                end
            end

            DACC, IACC: begin
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                if (bus.ramstate == ACCESS) begin
                    state_d   = RESP;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    if (state_q == DACC) begin
                        dhit_d = 1'b1;
                        if (ram_ren_q) dmemload_d = bus.ramload;
                    end else begin
                        ihit_d     = 1'b1;
                        imemload_d = bus.ramload;
                    end
                end else if (bus.ramstate == ERROR || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    memerr_d  = 1'b1;
                end
            end

            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            memerr_q    <= 1'b0;
            imemload_q  <= '0;
            dmemload_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            memerr_q    <= memerr_d;
            imemload_q  <= imemload_d;
            dmemload_q  <= dmemload_d;
        end
    end

    assign bus.ramREN   = ram_ren_q;
    assign bus.ramWEN   = ram_wen_q;
    assign bus.ramaddr  = ram_addr_q;
    assign bus.ramstore = ram_store_q;
    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.memerr   = memerr_q;
    assign bus.imemload = imemload_q;
    assign bus.dmemload = dmemload_q;

endmodule
